// File: rtl/sseg_scan_driver_if.sv
// Bundles the load/display signals of the 4-digit seven-segment scan driver.
// master drives the digit data and blink request; slave is the driver itself.
interface sseg_scan_driver_if;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        blink;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    modport master (
        output load, din, dp_in, blank_in, blink,
        input  an, sseg, frame_tick
    );

    modport slave (
        input  load, din, dp_in, blank_in, blink,
        output an, sseg, frame_tick
    );
endinterface

// File: rtl/sseg_scan_driver.sv
// Purpose: time-multiplexed 4-digit hex seven-segment driver; optional blink via SSEG_BLINK_EN.
// Latency: a load shows on sseg the cycle after the capturing edge; all outputs decode registered state.
// Backpressure: none; load is accepted every cycle and the scan free-runs.
module sseg_scan_driver #(
    parameter int REFRESH_DVSR = 4,
    parameter int BLINK_FRAMES = 2
) (
    input logic              clk,
    input logic              reset,
    sseg_scan_driver_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DVSR);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DVSR - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    logic [15:0]   dig_reg;
    logic [3:0]    dp_reg;
    logic [3:0]    blank_reg;
    logic          cnt_wrap;
    logic          dark;
    logic [3:0]    cur_dig;
    logic [6:0]    seg7;

    assign cnt_wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            slot      <= 2'd0;
            dig_reg   <= 16'h0000;
            dp_reg    <= 4'b0000;
            blank_reg <= 4'b0000;
        end else begin
            if (bus.load) begin
                dig_reg   <= bus.din;
                dp_reg    <= bus.dp_in;
                blank_reg <= bus.blank_in;
            end
            if (cnt_wrap) begin
                cnt  <= '0;
                slot <= slot + 2'd1;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

    assign bus.frame_tick = cnt_wrap && (slot == 2'd3);

`ifdef SSEG_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    // Held at zero while blink is low so the display is visible as soon as blink rises.
    always_ff @(posedge clk) begin
        if (reset || !bus.blink) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_tick) begin
            if (frame_cnt == FRAME_MAX) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + FW'(1);
            end
        end
    end

    assign dark = blink_phase;
`else
    logic unused_blink;
    assign unused_blink = bus.blink;
    assign dark         = 1'b0;
`endif

    assign cur_dig = dig_reg[{slot, 2'b00} +: 4];

    always_comb begin
        seg7 = 7'b1111111;
        case (cur_dig)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            4'hF: seg7 = 7'b0001110;
            default: seg7 = 7'b1111111;
        endcase
    end

    always_comb begin
        bus.sseg = {~dp_reg[slot], seg7};
        if (blank_reg[slot] || dark) begin
            bus.sseg = 8'hFF;
        end
    end

    assign bus.an = ~(4'b0001 << slot);
endmodule
